// File: rtl/seq_adder_pkg.sv
// Shared definitions for the multi-cycle sequential adder: FSM encodings and
// the counter-width helper.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Ceiling log2 evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_adder_chunk_add.sv
// CHUNK-bit combinational ripple adder built from full-adder cells.
// c_msb is the carry into the top bit, used for signed-overflow detection.
module chunk_add
  import seq_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder: {cout, sum} = a + b + cin computed CHUNK bits per cycle,
// LSB first, behind a start/busy/done handshake.
// Optional feature: define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (clog2(N) < 1) ? 1 : clog2(N);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] slice_s_c;
  logic             slice_co_c;
  logic [WIDTH-1:0] sum_full_c;

`ifdef SEQ_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
  logic             slice_cmsb_c;
`else
  // Carry into the top bit is only needed for overflow; left unconsumed here.
  logic             unused_cmsb_c;
`endif

  // Slice adder on the low CHUNK bits of the operand shift registers.
  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_sh_q[CHUNK-1:0]),
    .y     (b_sh_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (slice_s_c),
    .co    (slice_co_c),
`ifdef SEQ_ADDER_OVF_EN
    .c_msb (slice_cmsb_c)
`else
    .c_msb (unused_cmsb_c)
`endif
  );

  // Partial-sum shift register holding earlier slices; absent when N == 1.
  if (N > 1) begin : g_multi
    localparam int unsigned SHW = WIDTH - CHUNK;
    logic [SHW-1:0] sum_sh_q, sum_sh_d;

    // Shift each new slice in at the top while running.
    always_comb begin
      sum_sh_d = sum_sh_q;
      if (state_q == RUN) begin
        sum_sh_d = SHW'({slice_s_c, sum_sh_q} >> CHUNK);
      end
    end

    // Partial-sum register.
    always_ff @(posedge clk) begin
      if (rst) sum_sh_q <= '0;
      else     sum_sh_q <= sum_sh_d;
    end

    assign sum_full_c = {slice_s_c, sum_sh_q};
  end else begin : g_single
    assign sum_full_c = slice_s_c;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        carry_d = slice_co_c;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          sum_d   = sum_full_c;
          cout_d  = slice_co_c;
`ifdef SEQ_ADDER_OVF_EN
          ovf_d   = slice_cmsb_c ^ slice_co_c;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SEQ_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// Directed testbench for seq_adder in three shapes: 16/4, 8/1 and 8/8.
// Overflow checks are compiled in when SEQ_ADDER_OVF_EN is defined.
module tb_seq_adder;

  logic clk;
  logic rst;

  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start8s, cin8s, busy8s, done8s, cout8s, ovf8s;
  logic [7:0]  a8s, b8s, sum8s;
  logic        start8p, cin8p, busy8p, done8p, cout8p, ovf8p;
  logic [7:0]  a8p, b8p, sum8p;

  int n_tests;
  int n_fail;

  seq_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  seq_adder #(.WIDTH(8), .CHUNK(1)) u_w8s (
    .clk(clk), .rst(rst), .start(start8s), .a(a8s), .b(b8s), .cin(cin8s),
    .busy(busy8s), .done(done8s), .sum(sum8s), .cout(cout8s)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(ovf8s)
`endif
  );

  seq_adder #(.WIDTH(8), .CHUNK(8)) u_w8p (
    .clk(clk), .rst(rst), .start(start8p), .a(a8p), .b(b8p), .cin(cin8p),
    .busy(busy8p), .done(done8p), .sum(sum8p), .cout(cout8p)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(ovf8p)
`endif
  );

`ifndef SEQ_ADDER_OVF_EN
  assign ovf16 = 1'b0;
  assign ovf8s = 1'b0;
  assign ovf8p = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16/4 add from idle: busy in cycles 1..4, done only in cycle 5.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                       input logic exp_ovf);
    logic [15:0] prev;
    prev    = sum16;
    start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start16 = 1'b0;
      check($sformatf("%s busy c%0d", tag, c), 32'(busy16), 32'(1));
      check($sformatf("%s done c%0d", tag, c), 32'(done16), 32'(0));
      check($sformatf("%s held c%0d", tag, c), 32'(sum16), 32'(prev));
    end
    tick();
    check({tag, " done"}, 32'(done16), 32'(1));
    check({tag, " busy"}, 32'(busy16), 32'(0));
    check({tag, " sum"},  32'(sum16),  32'(exp_sum));
    check({tag, " cout"}, 32'(cout16), 32'(exp_cout));
`ifdef SEQ_ADDER_OVF_EN
    check({tag, " ovf"},  32'(ovf16),  32'(exp_ovf));
`else
    if (exp_ovf !== 1'bx) check({tag, " ovf tie"}, 32'(ovf16), 32'(0));
`endif
    tick();
    check({tag, " done drop"}, 32'(done16), 32'(0));
    check({tag, " sum hold"},  32'(sum16),  32'(exp_sum));
  endtask

  // One 8/1 add from idle: busy in cycles 1..8, done in cycle 9.
  task automatic run8s(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    start8s = 1'b1; a8s = a; b8s = b; cin8s = cin;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start8s = 1'b0;
      check($sformatf("%s busy c%0d", tag, c), 32'(busy8s), 32'(1));
      check($sformatf("%s done c%0d", tag, c), 32'(done8s), 32'(0));
    end
    tick();
    check({tag, " done"}, 32'(done8s), 32'(1));
    check({tag, " sum"},  32'(sum8s),  32'(exp_sum));
    check({tag, " cout"}, 32'(cout8s), 32'(exp_cout));
    tick();
    check({tag, " done drop"}, 32'(done8s), 32'(0));
  endtask

  initial begin
    logic [8:0] exp9;
    logic       exp_v;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8s = 1'b0; a8s = '0; b8s = '0; cin8s = 1'b0;
    start8p = 1'b0; a8p = '0; b8p = '0; cin8p = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values.
    check("rst busy", 32'(busy16), 32'(0));
    check("rst done", 32'(done16), 32'(0));
    check("rst sum",  32'(sum16),  32'(0));
    check("rst cout", 32'(cout16), 32'(0));
    check("rst ovf",  32'(ovf16),  32'(0));
    check("rst done8s", 32'(done8s), 32'(0));
    check("rst busy8p", 32'(busy8p), 32'(0));
    tick();

    // Basic carries across slices, wrap, and signed overflow.
    run16("w16 ff+1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run16("w16 ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("w16 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("w16 cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Start held through RUN with changing operands, then back-to-back start.
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      check($sformatf("hold busy c%0d", c), 32'(busy16), 32'(1));
      check($sformatf("hold done c%0d", c), 32'(done16), 32'(0));
      check($sformatf("hold sum c%0d", c),  32'(sum16),  32'(16'h5556));
    end
    tick();
    check("hold done", 32'(done16), 32'(1));
    check("hold sum",  32'(sum16),  32'(16'h2346));
    check("hold cout", 32'(cout16), 32'(0));
    a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start16 = 1'b0;
      check($sformatf("b2b busy c%0d", c), 32'(busy16), 32'(1));
      check($sformatf("b2b done c%0d", c), 32'(done16), 32'(0));
      check($sformatf("b2b sum c%0d", c),  32'(sum16),  32'(16'h2346));
    end
    tick();
    check("b2b done", 32'(done16), 32'(1));
    check("b2b sum",  32'(sum16),  32'(16'h0001));
    check("b2b cout", 32'(cout16), 32'(1));
`ifdef SEQ_ADDER_OVF_EN
    check("b2b ovf",  32'(ovf16),  32'(1));
`endif
    tick();
    check("b2b done drop", 32'(done16), 32'(0));

    // Reset in cycle 2 of a run aborts it.
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy16), 32'(0));
    check("abort done", 32'(done16), 32'(0));
    check("abort sum",  32'(sum16),  32'(0));
    check("abort cout", 32'(cout16), 32'(0));
    check("abort ovf",  32'(ovf16),  32'(0));
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort no done c%0d", c), 32'(done16), 32'(0));
    end
    run16("w16 post-abort", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Bit-serial shape.
    run8s("w8s aa+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
    run8s("w8s 3c+0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

    // Single-cycle shape: sweep with back-to-back starts, done every 2nd cycle.
    start8p = 1'b1;
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib += 17) begin
        for (int ic = 0; ic < 2; ic++) begin
          a8p = 8'(ia); b8p = 8'(ib); cin8p = 1'(ic);
          exp9 = 9'(ia + ib + ic);
          exp_v = (a8p[7] == b8p[7]) && (exp9[7] != a8p[7]);
          tick();
          check("w8p busy", 32'(busy8p), 32'(1));
          tick();
          check("w8p done", 32'(done8p), 32'(1));
          check($sformatf("w8p %0h+%0h+%0d", ia, ib, ic), 32'({cout8p, sum8p}), 32'(exp9));
`ifdef SEQ_ADDER_OVF_EN
          check($sformatf("w8p ovf %0h+%0h+%0d", ia, ib, ic), 32'(ovf8p), 32'(exp_v));
`endif
        end
      end
    end
    start8p = 1'b0;
    tick();
    check("w8p idle done", 32'(done8p), 32'(0));
    check("w8p idle busy", 32'(busy8p), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
